// File: rtl/ttd_pkg.sv
// Shared types and constants for the TTD measurement sequencer.
//   ttd_state_t        - sequencer state encoding
//   TTD_TIMER_BITS     - default width of one charge-time sample / result
//   TTD_CLK_PERIOD_NS  - system clock period (40 MHz), used by benches
package ttd_pkg;

    localparam int unsigned TTD_TIMER_BITS    = 8;
    localparam int unsigned TTD_CLK_PERIOD_NS = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISCHARGE,
        ST_CHARGE,
        ST_ACCUM,
        ST_DONE
    } ttd_state_t;

endpackage

// File: rtl/ttd_meas_ctrl_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
//   clk, rst : system clock, synchronous active-high reset (flops reset to 0)
//   d_in     : asynchronous input
//   d_sync   : input resynchronised to clk, two cycles of latency
module cmp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign d_sync = sync_q;

endmodule

// File: rtl/ttd_meas_ctrl.sv
// TTD measurement sequencer: discharges the sensing capacitor, times its charge
// to the comparator threshold, averages 2^AVG_LOG2 samples and offers the
// result over a valid/ready handshake.
//   clk, rst       : system clock, synchronous active-high reset
//   start          : one-cycle request for one averaged conversion (ignored while busy)
//   continuous     : restart automatically after each accepted result
//   cmp_in         : asynchronous comparator output (high above threshold)
//   rst_cap        : high discharges the capacitor, low lets it charge
//   busy           : conversion in progress until its result is accepted
//   result         : averaged charge time in clk cycles
//   result_valid   : result/timeout valid, held until result_ready
//   result_ready   : consumer accepts the result
//   timeout        : at least one sample of this result saturated
module ttd_meas_ctrl
    import ttd_pkg::*;
#(
    parameter int unsigned TIMER_BITS       = TTD_TIMER_BITS,
    parameter int unsigned AVG_LOG2         = 2,
    parameter int unsigned DISCHARGE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  cmp_in,
    output logic                  rst_cap,
    output logic                  busy,
    output logic [TIMER_BITS-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  timeout
);

    localparam int unsigned ACC_BITS = TIMER_BITS + AVG_LOG2;
    localparam int unsigned CNT_BITS = TIMER_BITS + 1;
    localparam int unsigned IDX_BITS = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned DIS_BITS = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;

    localparam logic [DIS_BITS-1:0] DIS_LAST = DIS_BITS'(DISCHARGE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'((1 << TIMER_BITS) - 1);
    localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'((1 << AVG_LOG2) - 1);

    ttd_state_t              state_q,   state_d;
    logic [DIS_BITS-1:0]     dis_cnt_q, dis_cnt_d;
    logic [CNT_BITS-1:0]     chg_cnt_q, chg_cnt_d;
    logic [IDX_BITS-1:0]     idx_q,     idx_d;
    logic [ACC_BITS-1:0]     acc_q,     acc_d;
    logic [TIMER_BITS-1:0]   sample_q,  sample_d;
    logic [TIMER_BITS-1:0]   result_q,  result_d;
    logic                    to_q,      to_d;
    logic                    rst_cap_q, rst_cap_d;
    logic                    busy_q,    busy_d;
    logic                    valid_q,   valid_d;
    logic                    cmp_s;

    cmp_sync u_cmp_sync (
        .clk    (clk),
        .rst    (rst),
        .d_in   (cmp_in),
        .d_sync (cmp_s)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dis_cnt_q <= '0;
            chg_cnt_q <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            sample_q  <= '0;
            result_q  <= '0;
            to_q      <= 1'b0;
            rst_cap_q <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dis_cnt_q <= dis_cnt_d;
            chg_cnt_q <= chg_cnt_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            result_q  <= result_d;
            to_q      <= to_d;
            rst_cap_q <= rst_cap_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    // Next state and datapath; counters idle at zero outside their own state
    always_comb begin
        state_d   = state_q;
        dis_cnt_d = '0;
        chg_cnt_d = '0;
        idx_d     = idx_q;
        acc_d     = acc_q;
        sample_d  = sample_q;
        result_d  = result_q;
        to_d      = to_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start || continuous) begin
                    state_d = ST_DISCHARGE;
                    acc_d   = '0;
                    idx_d   = '0;
                    to_d    = 1'b0;
                end
            end
            ST_DISCHARGE: begin
                // Minimum time is met; a capacitor still above threshold extends it
                if (dis_cnt_q < DIS_LAST) begin
                    dis_cnt_d = dis_cnt_q + DIS_BITS'(1);
                end else begin
                    dis_cnt_d = dis_cnt_q;
                end
                if ((dis_cnt_q >= DIS_LAST) && !cmp_s) begin
                    state_d = ST_CHARGE;
                end
            end
            ST_CHARGE: begin
                if (cmp_s) begin
                    sample_d = chg_cnt_q[TIMER_BITS-1:0];
                    state_d  = ST_ACCUM;
                end else if (chg_cnt_q >= CNT_MAX) begin
                    sample_d = '1;
                    to_d     = 1'b1;
                    state_d  = ST_ACCUM;
                end else begin
                    chg_cnt_d = chg_cnt_q + CNT_BITS'(1);
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + ACC_BITS'(sample_q);
                if (idx_q == IDX_LAST) begin
                    idx_d    = '0;
                    result_d = TIMER_BITS'(acc_d >> AVG_LOG2);
                    state_d  = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_BITS'(1);
                    state_d = ST_DISCHARGE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    if (continuous) begin
                        state_d = ST_DISCHARGE;
                        acc_d   = '0;
                        idx_d   = '0;
                        to_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs follow the state being entered
    always_comb begin
        rst_cap_d = (state_d != ST_CHARGE);
        busy_d    = (state_d != ST_IDLE);
        valid_d   = (state_d == ST_DONE);
    end

    assign rst_cap      = rst_cap_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_ttd_meas_ctrl.sv
// Self-checking bench for ttd_meas_ctrl. A model turns the applied charge
// times into expected averaged results; a monitor checks protocol rules every
// cycle and scores each transfer; directed steps pin literal values.
module tb_ttd_meas_ctrl;
    import ttd_pkg::*;

    localparam int TB_BITS = int'(TTD_TIMER_BITS);
    localparam int AVG     = 2;
    localparam int DC      = 16;
    localparam int NSAMP   = 1 << AVG;
    localparam int SAT     = (1 << TB_BITS) - 1;
    localparam int PER     = int'(TTD_CLK_PERIOD_NS);

    logic               clk, rst;
    logic               start, continuous, cmp_in, result_ready;
    logic               rst_cap, busy, result_valid, timeout;
    logic [TB_BITS-1:0] result;

    logic               start0, cmp0, ready0;
    logic               rst_cap0, busy0, valid0, timeout0;
    logic [TB_BITS-1:0] result0;

    int n_chk, n_fail, n_xfer, last_res;
    bit last_to, chk_en;
    int exp_q[$];

    ttd_meas_ctrl #(.TIMER_BITS(TB_BITS), .AVG_LOG2(AVG), .DISCHARGE_CYCLES(DC)) u_dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .cmp_in(cmp_in),
        .rst_cap(rst_cap), .busy(busy), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .timeout(timeout)
    );

    ttd_meas_ctrl #(.TIMER_BITS(TB_BITS), .AVG_LOG2(0), .DISCHARGE_CYCLES(DC)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .continuous(1'b0), .cmp_in(cmp0),
        .rst_cap(rst_cap0), .busy(busy0), .result(result0), .result_valid(valid0),
        .result_ready(ready0), .timeout(timeout0)
    );

    initial begin
        clk = 1'b0;
        forever #12.5ns clk = ~clk;
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Poll rst_cap once per cycle, 1 ns after the edge; n = edges waited
    task automatic wait_cap(input logic lvl, input int lim, output int n);
        n = 0;
        while (rst_cap !== lvl && n < lim) begin
            @(posedge clk); #1ns;
            n++;
        end
        chk(rst_cap === lvl, "wait_rst_cap", n, lim);
    endtask

    // One charge: comparator trips t_ns after rst_cap falls
    task automatic charge(input int t_ns);
        int n;
        wait_cap(1'b0, 400, n);
        exp_q.push_back((t_ns + PER - 1) / PER + 2);
        repeat (t_ns - 1) #1ns;
        cmp_in = 1'b1;
        wait_cap(1'b1, 300, n);
        cmp_in = 1'b0;
    endtask

    // One charge where the comparator never trips
    task automatic charge_to();
        int n;
        wait_cap(1'b0, 400, n);
        exp_q.push_back(-1);
        wait_cap(1'b1, 300, n);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1ns;
        start = 1'b0;
    endtask

    task automatic accept();
        int n = 0;
        while (!result_valid && n < 1500) begin
            @(posedge clk); #1ns;
            n++;
        end
        chk(result_valid, "wait_valid", n, 1500);
        result_ready = 1'b1;
        @(posedge clk); #1ns;
        result_ready = 1'b0;
    endtask

    // Per-cycle protocol checks and transfer scoring
    task automatic monitor();
        bit pv, pr, pto, pcap;
        int pres, hi_run, lo_run, sum, nto, er, tol, e;
        pv = 0; pr = 0; pto = 0; pcap = 1; pres = 0; hi_run = 0; lo_run = 0;
        forever begin
            @(negedge clk);
            if (!chk_en || rst) begin
                pv = 0; pr = 0; pcap = 1; hi_run = 0; lo_run = 0;
            end else begin
                if (!busy)
                    chk(rst_cap && !result_valid, "idle_outputs", int'({rst_cap, result_valid}), 2);
                if (result_valid)
                    chk(rst_cap && busy, "valid_outputs", int'({rst_cap, busy}), 3);
                if (pv && !pr)
                    chk(result_valid && int'(result) == pres && timeout == pto,
                        "hold_stable", int'(result), pres);
                if (busy && rst_cap) hi_run++;
                if (busy && !rst_cap && pcap) begin
                    chk(hi_run >= DC, "discharge_len", hi_run, DC);
                    hi_run = 0;
                end
                if (!busy) hi_run = 0;
                if (!rst_cap) lo_run++;
                else if (!pcap) begin
                    chk(lo_run <= SAT + 1, "charge_len", lo_run, SAT + 1);
                    lo_run = 0;
                end
                if (result_valid && result_ready) begin
                    n_xfer++;
                    last_res = int'(result);
                    last_to  = timeout;
                    if (exp_q.size() < NSAMP) begin
                        chk(1'b0, "xfer_samples", exp_q.size(), NSAMP);
                    end else begin
                        sum = 0; nto = 0;
                        for (int i = 0; i < NSAMP; i++) begin
                            e = exp_q.pop_front();
                            if (e < 0) begin sum += SAT; nto++; end
                            else sum += e;
                        end
                        er  = sum / NSAMP;
                        tol = (nto == NSAMP) ? 0 : 1;
                        chk(int'(result) >= er - tol && int'(result) <= er + tol,
                            "xfer_result", int'(result), er);
                        chk(timeout == (nto > 0), "xfer_timeout", int'(timeout), int'(nto > 0));
                    end
                end
                pv = result_valid; pr = result_ready; pres = int'(result);
                pto = timeout; pcap = rst_cap;
            end
        end
    endtask

    initial begin : main
        int n, x0;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; cmp_in = 1'b0; result_ready = 1'b0;
        start0 = 1'b0; cmp0 = 1'b0; ready0 = 1'b0;
        chk_en = 1'b0; n_chk = 0; n_fail = 0; n_xfer = 0; last_res = 0; last_to = 1'b0;
        fork monitor(); join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1ns;
        chk(rst_cap == 1'b1, "reset_rst_cap", int'(rst_cap), 1);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        chk(result_valid == 1'b0, "reset_valid", int'(result_valid), 0);
        chk(int'(result) == 0, "reset_result", int'(result), 0);
        chk(timeout == 1'b0, "reset_timeout", int'(timeout), 0);
        chk(rst_cap0 && !busy0 && !valid0, "reset_dut0", int'({rst_cap0, busy0, valid0}), 4);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1ns;

        // No averaging: single 3260 ns charge -> 133 +/- 1
        start0 = 1'b1;
        @(posedge clk); #1ns;
        start0 = 1'b0;
        n = 0;
        while (rst_cap0 && n < 400) begin @(posedge clk); #1ns; n++; end
        chk(!rst_cap0 && n == DC, "avg0_charge_start", n, DC);
        repeat (3260 - 1) #1ns;
        cmp0 = 1'b1;
        n = 0;
        while (!valid0 && n < 400) begin @(posedge clk); #1ns; n++; end
        chk(valid0, "avg0_valid", n, 400);
        chk(int'(result0) >= 132 && int'(result0) <= 134, "avg0_result", int'(result0), 133);
        chk(!timeout0, "avg0_timeout", int'(timeout0), 0);
        ready0 = 1'b1;
        @(posedge clk); #1ns;
        ready0 = 1'b0;
        cmp0 = 1'b0;
        chk(!busy0 && !valid0, "avg0_release", int'({busy0, valid0}), 0);

        // Four-sample average, start-to-charge latency
        do_start();
        chk(busy, "start_busy", int'(busy), 1);
        wait_cap(1'b0, 400, n);
        chk(n == DC, "charge_latency", n, DC);
        charge(3260); charge(4305); charge(5350); charge(4305);
        accept();
        chk(last_res >= 173 && last_res <= 175, "avg4_literal", last_res, 174);
        chk(!last_to, "avg4_timeout", int'(last_to), 0);
        chk(!busy, "busy_after_xfer", int'(busy), 0);

        // Comparator never trips: saturated samples
        do_start();
        repeat (NSAMP) charge_to();
        accept();
        chk(last_res == SAT, "timeout_result", last_res, SAT);
        chk(last_to, "timeout_flag", int'(last_to), 1);

        // Continuous mode with a stalled consumer
        continuous = 1'b1;
        @(posedge clk); #1ns;
        chk(busy, "cont_autostart", int'(busy), 1);
        repeat (NSAMP) charge(1010);
        n = 0;
        while (!result_valid && n < 400) begin @(posedge clk); #1ns; n++; end
        chk(result_valid, "cont_valid", n, 400);
        repeat (50) begin @(posedge clk); #1ns; end
        chk(result_valid && rst_cap, "cont_stalled", int'({result_valid, rst_cap}), 3);
        accept();
        chk(busy, "cont_restart_busy", int'(busy), 1);
        wait_cap(1'b0, 400, n);
        chk(n == DC, "cont_restart_latency", n, DC);
        continuous = 1'b0;
        repeat (NSAMP) charge(1010);
        accept();
        chk(!busy, "cont_stop_idle", int'(busy), 0);

        // Comparator stuck high through discharge; start pulsed while busy
        cmp_in = 1'b1;
        do_start();
        repeat (2) begin @(posedge clk); #1ns; end
        start = 1'b1;
        @(posedge clk); #1ns;
        start = 1'b0;
        repeat (DC + 7) begin @(posedge clk); #1ns; end
        chk(rst_cap, "stuck_hold", int'(rst_cap), 1);
        cmp_in = 1'b0;
        wait_cap(1'b0, 20, n);
        chk(DC + 10 + n >= DC + 11 && DC + 10 + n <= DC + 14, "stuck_release", DC + 10 + n, DC + 13);
        x0 = n_xfer;
        repeat (NSAMP) charge(810);
        accept();
        repeat (40) begin @(posedge clk); #1ns; end
        chk(!busy && !result_valid, "no_extra_conv", int'({busy, result_valid}), 0);
        chk(n_xfer == x0 + 1, "xfer_count", n_xfer - x0, 1);

        // Reset in the middle of a charge
        do_start();
        wait_cap(1'b0, 400, n);
        repeat (10) begin @(posedge clk); #1ns; end
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1ns;
        chk(rst_cap && !busy && !result_valid, "midreset_outputs",
            int'({rst_cap, busy, result_valid}), 4);
        chk(int'(result) == 0 && !timeout, "midreset_result", int'(result), 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (5) begin @(posedge clk); #1ns; end
        chk(!busy && rst_cap, "midreset_idle", int'({busy, rst_cap}), 1);
        chk_en = 1'b1;

        repeat (5) begin @(posedge clk); #1ns; end
        chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
